// File: rtl/mem_dma_copier.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dma_copier
//  Purpose  : Bus initiator on the picorv32 native memory interface that
//             copies a block of 32-bit words from src to dst, strictly one
//             read followed by one write per word, ascending addresses.
//  Revision : 1.0  initial release
// ============================================================================
module mem_dma_copier #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             error_o,
    output logic [CNT_W-1:0] words_done_o,
    output logic             mem_valid_o,
    output logic             mem_instr_o,
    input  logic             mem_ready_i,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_wstrb_o,
    input  logic [31:0]      mem_rdata_i
);

    // Wait counter only needs to reach TIMEOUT-1; keep at least one bit.
    localparam int             TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_GAP_R  = 3'd2,
        S_WRITE  = 3'd3,
        S_GAP_W  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             error_q, error_d;
    logic             abort_seen_q, abort_seen_d;
    logic             valid_q, valid_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;   // doubles as the read buffer
    logic [3:0]       wstrb_q, wstrb_d;
    logic [TO_W-1:0]  to_q, to_d;

    logic w_abort;
    logic w_to_hit;

    assign w_abort  = abort_seen_q | abort_i;
    assign w_to_hit = (TIMEOUT > 0) && (to_q == TO_LAST);

    // Next-state and registered-output computation for the copy sequencer.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        remain_d     = remain_q;
        words_d      = words_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        error_d      = error_q;
        abort_seen_d = abort_seen_q | (abort_i && (state_q != S_IDLE));
        valid_d      = valid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        to_d         = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d        = src_addr_i & 32'hFFFF_FFFC;
                    dst_d        = dst_addr_i & 32'hFFFF_FFFC;
                    remain_d     = count_i;
                    words_d      = '0;
                    aborted_d    = 1'b0;
                    error_d      = 1'b0;
                    abort_seen_d = 1'b0;
                    busy_d       = 1'b1;
                    if (count_i == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_READ;
                        valid_d = 1'b1;
                        addr_d  = src_addr_i & 32'hFFFF_FFFC;
                        wstrb_d = 4'b0000;
                    end
                end
            end
            S_READ: begin
                if (mem_ready_i) begin
                    wdata_d = mem_rdata_i;
                    valid_d = 1'b0;
                    state_d = S_GAP_R;
                end else if (w_to_hit) begin
                    valid_d = 1'b0;
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_GAP_R: begin
                if (w_abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    valid_d = 1'b1;
                    addr_d  = dst_q;
                    wstrb_d = 4'b1111;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ready_i) begin
                    valid_d  = 1'b0;
                    wstrb_d  = 4'b0000;
                    words_d  = words_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    src_d    = src_q + 32'd4;
                    dst_d    = dst_q + 32'd4;
                    state_d  = S_GAP_W;
                end else if (w_to_hit) begin
                    valid_d = 1'b0;
                    wstrb_d = 4'b0000;
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_GAP_W: begin
                if (remain_q == '0) begin
                    state_d = S_FINISH;
                end else if (w_abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    valid_d = 1'b1;
                    addr_d  = src_q;
                    wstrb_d = 4'b0000;
                    state_d = S_READ;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset takes effect immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            remain_q     <= '0;
            words_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            error_q      <= 1'b0;
            abort_seen_q <= 1'b0;
            valid_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= 4'b0000;
            to_q         <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            remain_q     <= remain_d;
            words_q      <= words_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            error_q      <= error_d;
            abort_seen_q <= abort_seen_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            to_q         <= to_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign aborted_o    = aborted_q;
    assign error_o      = error_q;
    assign words_done_o = words_q;
    assign mem_valid_o  = valid_q;
    assign mem_instr_o  = 1'b0;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_wstrb_o  = wstrb_q;

endmodule
`default_nettype wire
